// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the multiplexer scan sequencer.
//   State encoding, source count, chooser width and accumulator width.
package mux_scan_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEL  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int NSRC   = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 16;
  // Eight sources of DATA_W bits sum without overflow in DATA_W+3 bits.
  localparam int SUM_W  = DATA_W + 3;

endpackage

// File: rtl/mux_scan_sequencer_lowest_set_index8.sv
// Combinational 8-bit priority encoder: lowest set bit index.
//   i_vec  : candidate bit vector
//   o_idx  : index of the lowest set bit (0 when none are set)
//   o_none : high when i_vec is all zeros
module lowest_set_index8 (
  input  logic [7:0] i_vec,
  output logic [2:0] o_idx,
  output logic       o_none
);

  always_comb begin
    o_idx  = 3'd0;
    o_none = (i_vec == 8'd0);
    // Descending walk so the lowest set bit is the final assignment.
    for (int k = 7; k >= 0; k--) begin
      if (i_vec[k]) o_idx = 3'(k);
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an 8:1 operand multiplexer.
//   Walks enabled sources in ascending order, captures each multiplexer
//   output and hands it downstream on a valid/ready handshake, then pulses
//   done for one cycle.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start, en_mask      : scan request and source enable mask (IDLE only)
//   sel_data            : multiplexer output for the current chooser
//   chooser             : registered select, value k-1 selects source Ak
//   out_data/out_index  : captured sample and the chooser it came from
//   out_valid/out_ready : downstream handshake
//   busy, done          : not-IDLE flag, end-of-scan pulse
//   sum_out             : sum of accepted samples (only with SCAN_SUM_EN)
// Optional feature macro: SCAN_SUM_EN
//
// state | meaning
// IDLE  | waiting for start
// SEL   | chooser stable, sel_data captured at the end of this cycle
// OUT   | sample presented, waiting for handshake
// DONE  | one-cycle completion pulse
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NSRC-1:0]    en_mask,
  input  logic [WIDTH-1:0]   sel_data,
  output logic [SEL_W-1:0]   chooser,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_index,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
`ifdef SCAN_SUM_EN
  output logic [WIDTH+2:0]   sum_out,
`endif
  output logic               done
);

  logic [1:0]       r_state;
  logic [NSRC-1:0]  r_pending;
  logic [SEL_W-1:0] r_chooser;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_index;
  logic             r_out_valid;

  logic [NSRC-1:0]  w_enc_in;
  logic [SEL_W-1:0] w_enc_idx;
  logic             w_enc_none;
  logic             w_hs;
  logic             w_accept;

  // One encoder serves both the first pick (from the raw mask in IDLE) and
  // the next pick (from what is still pending in OUT). The current source's
  // bit is already cleared in SEL, so OUT sees only the remaining ones.
  assign w_enc_in = (r_state == ST_IDLE) ? en_mask : r_pending;

  lowest_set_index8 u_lsi (
    .i_vec  (w_enc_in),
    .o_idx  (w_enc_idx),
    .o_none (w_enc_none)
  );

  assign w_hs     = (r_state == ST_OUT) && r_out_valid && out_ready;
  assign w_accept = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_chooser   <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (!w_enc_none) begin
              r_pending <= en_mask;
              r_chooser <= w_enc_idx;
              r_state   <= ST_SEL;
            end else begin
              r_state   <= ST_DONE;
            end
          end
        end
        ST_SEL: begin
          r_out_data           <= sel_data;
          r_out_index          <= r_chooser;
          r_out_valid          <= 1'b1;
          r_pending[r_chooser] <= 1'b0;
          r_state              <= ST_OUT;
        end
        ST_OUT: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            if (w_enc_none) begin
              r_state <= ST_DONE;
            end else begin
              r_chooser <= w_enc_idx;
              r_state   <= ST_SEL;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_SUM_EN
  logic [WIDTH+2:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= '0;
    end else if (w_hs) begin
      r_sum <= r_sum + {3'b000, r_out_data};
    end
  end

  assign sum_out = r_sum;
`endif

  assign chooser   = r_chooser;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  en_mask = 8'h00;
  logic [15:0] sel_data;
  logic [2:0]  chooser;
  logic [15:0] out_data;
  logic [2:0]  out_index;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
`ifdef SCAN_SUM_EN
  logic [18:0] sum_out;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: what the current scan must still produce.
  logic [7:0]  scan_mask = 8'h00;
  int          exp_q[$];
  int          n_out = 0;
  int          done_cnt = 0;
  logic [31:0] model_sum = 0;
  logic [15:0] first_data = 16'h0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] prev_data = 16'h0;
  logic [2:0]  prev_idx = 3'd0;
  logic [2:0]  prev_ch = 3'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source Ak (chooser value k-1) carries 16'h0100*k.
  function automatic logic [15:0] src(input int ch);
    return 16'((ch + 1) * 256);
  endfunction

  assign sel_data = src(int'(chooser));

  mux_scan_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .en_mask   (en_mask),
    .sel_data  (sel_data),
    .chooser   (chooser),
    .out_data  (out_data),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef SCAN_SUM_EN
    .sum_out   (sum_out),
`endif
    .done      (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the scan model.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (busy && scan_mask != 8'h00)
        chk("chooser_enabled", {31'd0, scan_mask[chooser]}, 32'd1);
      if (prev_valid && !prev_ready) begin
        chk("valid_held", {31'd0, out_valid}, 32'd1);
        chk("data_stable", {16'd0, out_data}, {16'd0, prev_data});
        chk("index_stable", {29'd0, out_index}, {29'd0, prev_idx});
        chk("chooser_stable", {29'd0, chooser}, {29'd0, prev_ch});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("out_index", {29'd0, out_index}, 32'(e));
          chk("out_data", {16'd0, out_data}, {16'd0, src(e)});
          if (n_out == 0) first_data = out_data;
          model_sum = model_sum + {16'd0, src(e)};
          n_out++;
        end
      end
      if (done) begin
        chk("done_after_last", 32'(exp_q.size()), 32'd0);
        chk("done_no_valid", {31'd0, out_valid}, 32'd0);
`ifdef SCAN_SUM_EN
        chk("sum_out", {13'd0, sum_out}, model_sum);
`endif
        done_cnt++;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
      prev_ch    = chooser;
    end
  end

  // Runs one scan; lat is the number of cycles from the accepting edge to
  // the cycle in which done is seen.
  task automatic run_scan(input logic [7:0] mask, input int stall, input bit restart,
                          output int lat);
    int start_cyc;
    bit seen;
    scan_mask = mask;
    exp_q.delete();
    for (int k = 0; k < 8; k++) if (mask[k]) exp_q.push_back(k);
    model_sum = 0;
    n_out = 0;
    done_cnt = 0;
    first_data = 16'h0;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b1;
    en_mask = mask;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
    en_mask = 8'($urandom);
    if (stall > 0) begin
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk); #1;
        if (out_valid) seen = 1;
      end
      if (!seen) chk("valid_timeout", 32'd1, 32'd0);
      repeat (stall) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    if (restart) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      en_mask = 8'h01;
      @(posedge clk); #1 start = 1'b0;
    end
    seen = 0;
    lat = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      if (done) begin
        seen = 1;
        lat = cyc - start_cyc;
      end
    end
    if (!seen) chk("done_timeout", 32'd1, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("out_count", 32'(n_out), 32'($countones(mask)));
    chk("idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    #12;
    chk("rst_chooser", {29'd0, chooser}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_index", {29'd0, out_index}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Full mask, no back-pressure.
    run_scan(8'hFF, 0, 0, lat);
    chk("full_latency", 32'(lat), 32'd16);
    chk("full_count", 32'(n_out), 32'd8);
    chk("full_first", {16'd0, first_data}, 32'h0100);
    chk("full_chooser_end", {29'd0, chooser}, 32'd7);
`ifdef SCAN_SUM_EN
    chk("full_sum", {13'd0, sum_out}, 32'h02400);
`endif

    // Sparse mask: sources 2, 5, 7 only.
    run_scan(8'b1010_0100, 0, 0, lat);
    chk("sparse_latency", 32'(lat), 32'd6);
    chk("sparse_first", {16'd0, first_data}, 32'h0300);
    chk("sparse_chooser_end", {29'd0, chooser}, 32'd7);

    // Back-pressure for 5 cycles on the first sample.
    run_scan(8'h03, 5, 0, lat);
    chk("bp_latency", 32'(lat), 32'd9);
    chk("bp_first", {16'd0, first_data}, 32'h0100);

    // Empty mask.
    run_scan(8'h00, 0, 0, lat);
    chk("empty_latency", 32'(lat), 32'd0);
    chk("empty_count", 32'(n_out), 32'd0);

    // start while busy is ignored.
    run_scan(8'hFF, 0, 1, lat);
    chk("restart_latency", 32'(lat), 32'd16);

    // Reset asserted during OUT.
    scan_mask = 8'h0C;
    exp_q.delete();
    out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1; en_mask = 8'h0C;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_chooser", {29'd0, chooser}, 32'd0);
    chk("mid_rst_data", {16'd0, out_data}, 32'd0);
    chk("mid_rst_index", {29'd0, out_index}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
`ifdef SCAN_SUM_EN
    chk("mid_rst_sum", {13'd0, sum_out}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Clean scan after reset.
    run_scan(8'b0101_1001, 0, 0, lat);
    chk("post_rst_latency", 32'(lat), 32'd8);
    chk("post_rst_first", {16'd0, first_data}, 32'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
